// File: rtl/tick_edge_counter_if.sv
// Purpose : control/status bundle between a tick source and tick_edge_counter.
// Latency : n/a (wires only).
// Backpressure: none; the counter samples its inputs every clk and never stalls.
//
// Ports carried:
//   enable   - divided-clock tick (level; only its rising edge matters)
//   en_d     - count enable applied to detected edges
//   up_dn    - 1 = count up, 0 = count down
//   sat      - 1 = saturate at the bound, 0 = wrap
//   clr      - synchronous clear to 0
//   load     - synchronous load from load_val
//   load_val - value loaded when load=1
//   count    - registered count
//   tc       - registered one-cycle terminal-count pulse
//   pedge    - combinational rising-edge indicator of enable
interface tick_edge_counter_if #(
   parameter int C_SIZE = 2
);
   logic              enable;
   logic              en_d;
   logic              up_dn;
   logic              sat;
   logic              clr;
   logic              load;
   logic [C_SIZE-1:0] load_val;
   logic [C_SIZE-1:0] count;
   logic              tc;
   logic              pedge;

   // Driver side: the tick source / sequencing logic.
   modport master (
      output enable, en_d, up_dn, sat, clr, load, load_val,
      input  count, tc, pedge
   );

   // Counter side.
   modport slave (
      input  enable, en_d, up_dn, sat, clr, load, load_val,
      output count, tc, pedge
   );
endinterface

// File: rtl/tick_edge_counter.sv
// Purpose : counts rising edges of a divided-clock tick with programmable wrap bounds,
//           up/down direction, wrap/saturate mode, sync clear/load and a terminal-count pulse.
// Latency : tick rising edge to count change 1 clk; boundary step to tc high 1 clk.
// Backpressure: none; every qualified edge is acted on or consumed in the cycle it is seen.
//
// Ports:
//   clk   - single system clock, all state updates on its rising edge
//   reset - asynchronous active-low reset
//   bus   - tick_edge_counter_if.slave (enable, en_d, up_dn, sat, clr, load, load_val
//           in; count, tc, pedge out)
module tick_edge_counter #(
   parameter int C_SIZE = 2,   // counter width, 1..32
   parameter int C_MAX  = 3,   // upper bound, C_MIN < C_MAX <= 2^C_SIZE-1
   parameter int C_MIN  = 1    // lower / wrap-to bound, 0 <= C_MIN < C_MAX
) (
   input  logic                  clk,
   input  logic                  reset,
   tick_edge_counter_if.slave    bus
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter sanity
   // ------------------------------------------------------------------
   generate
      if (C_SIZE < 1 || C_SIZE > 32) begin : g_bad_size
         $error("tick_edge_counter: C_SIZE must be within 1..32");
      end
      if (C_MIN < 0 || C_MIN >= C_MAX) begin : g_bad_min
         $error("tick_edge_counter: need 0 <= C_MIN < C_MAX");
      end
      if (longint'(C_MAX) > ((longint'(1) << C_SIZE) - longint'(1))) begin : g_bad_max
         $error("tick_edge_counter: C_MAX does not fit in C_SIZE bits");
      end
   endgenerate

   localparam logic [C_SIZE-1:0] MAX_V = C_SIZE'(C_MAX);
   localparam logic [C_SIZE-1:0] MIN_V = C_SIZE'(C_MIN);
   localparam logic [C_SIZE-1:0] ONE_V = C_SIZE'(1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic              enable_dly_q;
   logic [C_SIZE-1:0] count_q;
   logic [C_SIZE-1:0] count_d;
   logic              tc_q;
   logic              tc_d;

   // ------------------------------------------------------------------
   // Edge detect
   // ------------------------------------------------------------------
   logic pedge;
   logic step;

   // enable_dly_q resets to 1, so a tick already high when reset releases
   // is treated as old news rather than a fresh edge.
   always_comb begin
      pedge = bus.enable & ~enable_dly_q;
      // An edge with en_d low is simply dropped; nothing remembers it.
      step  = pedge & bus.en_d;
   end

   // ------------------------------------------------------------------
   // Step value and boundary detection
   // ------------------------------------------------------------------
   // Comparisons use >= / <= rather than == so that out-of-range values
   // (after reset or an unclamped load) still move back into range and the
   // +1 / -1 paths can never overflow or underflow.
   logic [C_SIZE-1:0] step_val;
   logic              at_bound;

   always_comb begin
      step_val = count_q;
      at_bound = 1'b0;
      if (bus.up_dn) begin
         if (count_q >= MAX_V) begin
            at_bound = 1'b1;
            step_val = bus.sat ? MAX_V : MIN_V;
         end else begin
            step_val = count_q + ONE_V;
         end
      end else begin
         if (count_q <= MIN_V) begin
            at_bound = 1'b1;
            step_val = bus.sat ? MIN_V : MAX_V;
         end else begin
            step_val = count_q - ONE_V;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state: clear > load > step > hold
   // ------------------------------------------------------------------
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      if (bus.clr) begin
         count_d = '0;
      end else if (bus.load) begin
         // Loaded verbatim; a coincident edge is lost.
         count_d = bus.load_val;
      end else if (step) begin
         count_d = step_val;
         // tc marks boundary steps in both wrap and saturate mode.
         tc_d    = at_bound;
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         enable_dly_q <= 1'b1;
         count_q      <= '0;
         tc_q         <= 1'b0;
      end else begin
         enable_dly_q <= bus.enable;
         count_q      <= count_d;
         tc_q         <= tc_d;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.pedge = pedge;

endmodule

// File: tb/tb_tick_edge_counter.sv
// Purpose : directed bench for tick_edge_counter (default 2-bit and 8-bit 10..200 instances).
// Latency : expectations are queued when stimulus is driven and checked 1 clk later.
// Backpressure: n/a.
module tb_tick_edge_counter;

   logic clk;
   logic reset;

   tick_edge_counter_if #(.C_SIZE(2)) ifa ();
   tick_edge_counter_if #(.C_SIZE(8)) ifb ();

   tick_edge_counter #(.C_SIZE(2), .C_MAX(3), .C_MIN(1)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   tick_edge_counter #(.C_SIZE(8), .C_MAX(200), .C_MIN(10)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] cnt;
      logic [31:0] tc;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int c, input int t);
      sb.push_back('{tag, 32'(c), 32'(t)});
   endtask

   // Pop the oldest expectation and compare it with the observed outputs.
   task automatic score(input logic [31:0] obs_cnt, input logic [31:0] obs_tc);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL scoreboard_empty: observed=%0d expected=entry", obs_cnt);
      end else begin
         e = sb.pop_front();
         check({e.tag, "_count"}, obs_cnt, e.cnt);
         check({e.tag, "_tc"}, obs_tc, e.tc);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic score_a();
      score(32'(ifa.count), 32'(ifa.tc));
   endtask

   task automatic score_b();
      score(32'(ifb.count), 32'(ifb.tc));
   endtask

   // One tick on DUT A: high 3 clk, low 3 clk.
   task automatic pulse_a(input string tag, input int c, input int t);
      ifa.enable = 1'b1;
      #1;
      check({tag, "_pedge"}, 32'(ifa.pedge), 1);
      push(tag, c, t);
      adv();
      score_a();
      check({tag, "_pedge_held"}, 32'(ifa.pedge), 0);
      push({tag, "_after"}, c, 0);
      adv();
      score_a();
      adv();
      ifa.enable = 1'b0;
      repeat (3) adv();
   endtask

   task automatic sync_a(input string tag, input logic c_clr, input logic c_load,
                         input logic [1:0] val, input int c);
      ifa.clr      = c_clr;
      ifa.load     = c_load;
      ifa.load_val = val;
      push(tag, c, 0);
      adv();
      score_a();
      ifa.clr  = 1'b0;
      ifa.load = 1'b0;
   endtask

   initial begin
      reset        = 1'b0;
      ifa.enable   = 1'b1;
      ifa.en_d     = 1'b1;
      ifa.up_dn    = 1'b1;
      ifa.sat      = 1'b0;
      ifa.clr      = 1'b0;
      ifa.load     = 1'b0;
      ifa.load_val = '0;
      ifb.enable   = 1'b0;
      ifb.en_d     = 1'b1;
      ifb.up_dn    = 1'b0;
      ifb.sat      = 1'b0;
      ifb.clr      = 1'b0;
      ifb.load     = 1'b0;
      ifb.load_val = '0;

      // Reset state
      #12;
      check("rst_count", 32'(ifa.count), 0);
      check("rst_tc", 32'(ifa.tc), 0);
      check("rst_pedge", 32'(ifa.pedge), 0);
      check("rst_count_b", 32'(ifb.count), 0);

      // Release reset with enable already high: no edge
      adv();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push("held_high", 0, 0);
         adv();
         score_a();
      end
      check("held_high_pedge", 32'(ifa.pedge), 0);
      ifa.enable = 1'b0;
      repeat (3) adv();
      pulse_a("first_edge", 1, 0);

      // Wrap up: 1,2,3,1,2 with tc on the 3->1 step
      sync_a("clr0", 1'b1, 1'b0, 2'd0, 0);
      pulse_a("wrap_p1", 1, 0);
      pulse_a("wrap_p2", 2, 0);
      pulse_a("wrap_p3", 3, 0);
      pulse_a("wrap_p4", 1, 1);
      pulse_a("wrap_p5", 2, 0);

      // en_d low consumes edges; no catch-up afterwards
      ifa.en_d = 1'b0;
      pulse_a("end0_p1", 2, 0);
      pulse_a("end0_p2", 2, 0);
      ifa.en_d = 1'b1;
      pulse_a("end1_p3", 3, 0);

      // clr beats load and edge
      sync_a("load2", 1'b0, 1'b1, 2'd2, 2);
      ifa.clr      = 1'b1;
      ifa.load     = 1'b1;
      ifa.load_val = 2'd3;
      ifa.enable   = 1'b1;
      push("clr_wins", 0, 0);
      adv();
      score_a();
      ifa.clr  = 1'b0;
      ifa.load = 1'b0;
      push("clr_wins_hold", 0, 0);
      adv();
      score_a();
      ifa.enable = 1'b0;
      repeat (3) adv();

      // load beats edge; that edge is lost
      sync_a("load2b", 1'b0, 1'b1, 2'd2, 2);
      ifa.load     = 1'b1;
      ifa.load_val = 2'd3;
      ifa.enable   = 1'b1;
      push("load_wins", 3, 0);
      adv();
      score_a();
      ifa.load = 1'b0;
      push("load_wins_hold", 3, 0);
      adv();
      score_a();
      ifa.enable = 1'b0;
      repeat (3) adv();

      // Saturate down from 2 with C_MIN=1
      ifa.sat   = 1'b1;
      ifa.up_dn = 1'b0;
      sync_a("sat_load2", 1'b0, 1'b1, 2'd2, 2);
      pulse_a("satdn_p1", 1, 0);
      pulse_a("satdn_p2", 1, 1);
      pulse_a("satdn_p3", 1, 1);

      // Wrap down from out-of-range 0 goes to C_MAX
      ifa.sat = 1'b0;
      sync_a("clr1", 1'b1, 1'b0, 2'd0, 0);
      pulse_a("wrapdn_0", 3, 1);
      // Saturate up at C_MAX
      ifa.sat   = 1'b1;
      ifa.up_dn = 1'b1;
      pulse_a("satup", 3, 1);
      ifa.sat = 1'b0;
      pulse_a("wrapup", 1, 1);

      // 8-bit instance: down wrap from C_MIN=10 to C_MAX=200
      ifb.load     = 1'b1;
      ifb.load_val = 8'd10;
      push("b_load10", 10, 0);
      adv();
      score_b();
      ifb.load   = 1'b0;
      ifb.enable = 1'b1;
      #1;
      check("b_pedge", 32'(ifb.pedge), 1);
      push("b_wrapdn", 200, 1);
      adv();
      score_b();
      push("b_wrapdn_after", 200, 0);
      adv();
      score_b();
      ifb.enable = 1'b0;
      adv();

      // Asynchronous reset mid-count, between clock edges
      sync_a("pre_rst_load2", 1'b0, 1'b1, 2'd2, 2);
      #2;
      reset = 1'b0;
      #1;
      check("async_rst_count", 32'(ifa.count), 0);
      check("async_rst_tc", 32'(ifa.tc), 0);
      check("async_rst_count_b", 32'(ifb.count), 0);
      adv();
      reset = 1'b1;
      adv();
      pulse_a("post_rst", 1, 0);

      check("sb_drained", 32'(sb.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tick_edge_counter.md
Name: tick_edge_counter

Overview:
- Parametrised successor to the 2-bit clock-divider counter.
- Counts rising edges of a divided-clock tick (`enable`), not raw clock cycles.
- Adds the following over the 2-bit version:
  - generic width
  - programmable wrap bounds
  - up/down direction
  - wrap or saturate mode
  - synchronous load and clear
  - registered terminal-count pulse
- Sits downstream of the clock divider; feeds slower timing and sequencing logic.

Parameters:
- C_SIZE, 2, counter width in bits (1..32).
- C_MAX, 3, upper bound; must satisfy C_MIN < C_MAX <= 2^C_SIZE-1.
- C_MIN, 1, wrap-to / lower bound; 0 <= C_MIN < C_MAX.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  tick from clock divider; level signal, only its rising edge matters.
- en_d  in  1  count enable; a detected edge advances count only while en_d=1.
- up_dn  in  1  1 = count up, 0 = count down.
- sat  in  1  1 = saturate at bound, 0 = wrap.
- clr  in  1  synchronous clear of count to 0.
- load  in  1  synchronous load of count from load_val.
- load_val  in  C_SIZE  value loaded when load=1.
- count  out  C_SIZE  current count, registered.
- tc  out  1  registered terminal-count pulse.
- pedge  out  1  combinational rising-edge indicator of enable.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset=0), applied immediately regardless of clk:
  - count=0, tc=0, enable_dly=1.
  - enable_dly resets to 1 so an enable held high through reset release is not a false edge.
- Edge detect:
  - enable_dly is a 1-bit register of enable.
  - pedge = enable & ~enable_dly.
  - Exactly one pedge per low-to-high transition of enable; enable held high gives one pedge only.
- Update priority, evaluated at each rising clk edge:
  1. clr=1: count <= 0.
  2. else load=1: count <= load_val, stored as-is, no clamping.
  3. else pedge & en_d: step (see below).
  4. else: count holds.
- pedge with en_d=0 is consumed: count holds and no later catch-up occurs.
- Step, up (up_dn=1):
  - count < C_MAX: count+1.
  - count >= C_MAX, sat=0: C_MIN (wrap).
  - count >= C_MAX, sat=1: C_MAX (hold).
- Step, down (up_dn=0):
  - count > C_MIN: count-1.
  - count <= C_MIN, sat=0: C_MAX (wrap).
  - count <= C_MIN, sat=1: C_MIN (hold).
- Out-of-range values (after reset or load, e.g. 0 below C_MIN=1): step by the comparisons above.
  - Up from 0 gives 1.
  - Down from 0 gives C_MAX when wrapping.
- Arithmetic is C_SIZE bits; overflow never occurs because of the bound comparisons.
- tc:
  - Asserted for exactly one clk cycle, in the cycle after a step that hits a boundary.
  - Boundary step = up step at count >= C_MAX, or down step at count <= C_MIN, in wrap or saturate mode.
  - Otherwise tc=0; clr and load never raise tc.
- Latency:
  - enable rising edge to count change: 1 clk.
  - Boundary step to tc high: 1 clk.
- Simultaneous events:
  - clr wins over load and step.
  - load wins over step; that pedge is lost.
  - up_dn and sat are sampled only on the step cycle and may change freely between ticks.
- Reset mid-operation: all state returns to reset values at once; the first tick after release counts from 0.

Test Plan:
- Defaults, reset released with enable=1, en_d=1 -> no step; count stays 0 until enable falls and rises again, then count=1.
- Defaults, wrap up: 5 enable pulses (each high 3 clk, low 3 clk) -> count sequence 1,2,3,1,2; tc high exactly 1 clk after the 3->1 step.
- sat=1, up_dn=0, load_val=2 loaded, then 3 pulses -> count 1,1,1; tc pulses once per pulse at count 1.
- en_d=0 during 2 pulses, then en_d=1 for 1 pulse, from count=2 -> count holds 2, then becomes 3; no tc.
- Same cycle clr=1, load=1 (load_val=3) and pedge, from count=2 -> count=0, tc=0. Repeat with load only -> count=3, no step.
- C_SIZE=8, C_MAX=200, C_MIN=10, up_dn=0, sat=0: load 10, then 1 pulse -> count=200, tc=1 for one cycle.
- Assert reset mid-count at count=2, asynchronously between clk edges -> count=0 and tc=0 immediately, without waiting for a clk edge.
